phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clock  input  1  system clock, all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: instr_valid  input  1  an opcode is offered on opcode.
REQ-005 Port: opcode  input  8  instruction opcode, sampled on acceptance.
REQ-006 Port: stall  input  1  freezes phase advance, e.g. memory busy.
REQ-007 Port: instr_ready  output  1  sequencer can accept an opcode this cycle.
REQ-008 Port: clock_3, clock_5, clock_7  output  1 each  one-cycle phase strobes to the register selector.
REQ-009 Port: select_1, select_2, select_3  output  4 each  selector codes for phases 3, 5 and 7.
REQ-010 Port: phase  output  3  current phase: 0 = idle, 1..7 = P1..P7 (P8 encoded 0 with busy=1).
REQ-011 Port: busy  output  1  an instruction is in flight.
REQ-012 Port: instr_done  output  1  one-cycle pulse in the final phase.
REQ-013 Port: illegal_op  output  1  one-cycle pulse on an undecodable opcode.

Function
REQ-014 States SHALL be IDLE, P1..P8; there SHALL be no other reachable state.
REQ-015 Acceptance SHALL occur when instr_valid=1 and instr_ready=1 on a rising edge.
REQ-016 instr_ready SHALL be 1 in IDLE and in P8 with stall=0; 0 otherwise.
REQ-017 Decode table (select_1/select_2/select_3):
- 8'h55 PUSH EBP: 2/1/0
- 8'h5D POP EBP: 4/2/0
- 8'h89 MOV EBP,ESP: 0/2/0
- 8'hE8 CALL: 3/3/2
- 8'hC3 RET: 4/4/2
REQ-018 A legal opcode accepted in cycle T SHALL give: P1 at T+1, clock_3 at T+3, clock_5 at T+5, clock_7 at T+7, P8 with instr_done at T+8 (no stalls).
REQ-019 select_1..3 SHALL be registered at acceptance and held constant from P1 through P8.
REQ-020 In IDLE, select_1..3 SHALL be 0.
REQ-021 Each Pn with stall=0 SHALL advance to Pn+1 on the next edge.
REQ-022 P8 SHALL go to P1 if a new opcode is accepted that edge, else to IDLE.
REQ-023 Back-to-back instructions SHALL therefore issue every 8 cycles with no idle bubble.
REQ-024 While stall=1, the state SHALL hold.
REQ-025 While stall=1, clock_3/5/7 and instr_done SHALL be forced 0, and instr_ready SHALL be 0.
REQ-026 A strobe SHALL assert in the first stall-free cycle of its phase and only once per instruction.
REQ-027 stall in IDLE SHALL have no effect on acceptance.
REQ-028 An illegal opcode SHALL be accepted, SHALL pulse illegal_op for one cycle at T+1, and SHALL return the state to IDLE at T+1.
REQ-029 For an illegal opcode, no phase strobe or instr_done SHALL fire, and selects SHALL stay 0.
REQ-030 At most one of clock_3, clock_5, clock_7 SHALL be 1 in any cycle.
REQ-031 busy SHALL be 1 exactly in P1..P8.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE without waiting for a clock edge.
REQ-033 Under reset, all strobes, busy, instr_done and illegal_op SHALL be 0, selects 0 and phase 0, and instr_ready SHALL be 1 after release.
REQ-034 Reset asserted mid-instruction SHALL abort it with no further strobes.
REQ-035 The first acceptance after reset SHALL be possible on the first rising edge with reset_n=1.

Verification
REQ-036 Opcode 8'h55 at T, no stall: clock_3@T+3 with select_1=2, clock_5@T+5 with select_2=1, clock_7@T+7 with select_3=0, instr_done@T+8.
REQ-037 8'hE8 then 8'hC3 held valid: second acceptance at T+8, its clock_3@T+11 with select_1=4, and RET's select_3=2 at its clock_7.
REQ-038 8'h89 with stall=1 during cycles T+3..T+5: clock_3 fires at T+6 only, instr_done at T+11, and no strobes while stalled.
REQ-039 Opcode 8'hFF: illegal_op@T+1, IDLE@T+1, no strobes; a following 8'h5D at T+1 is accepted normally.
REQ-040 reset_n low at T+4 of 8'hC3: outputs zero asynchronously, no clock_5/clock_7, instr_ready=1 after release.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Handshake and strobe bundle between the instruction front end and the phase sequencer.
// The sequencer takes the slave side; the front end / register selector take the master side.
interface phase_sequencer_if;
  logic       instr_valid;
  logic [7:0] opcode;
  logic       stall;
  logic       instr_ready;
  logic       clock_3;
  logic       clock_5;
  logic       clock_7;
  logic [3:0] select_1;
  logic [3:0] select_2;
  logic [3:0] select_3;
  logic [2:0] phase;
  logic       busy;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    output instr_valid, opcode, stall,
    input  instr_ready, clock_3, clock_5, clock_7,
    input  select_1, select_2, select_3, phase, busy, instr_done, illegal_op
  );

  modport slave (
    input  instr_valid, opcode, stall,
    output instr_ready, clock_3, clock_5, clock_7,
    output select_1, select_2, select_3, phase, busy, instr_done, illegal_op
  );
endinterface

// File: rtl/phase_sequencer.sv
// Eight-phase instruction sequencer: decodes an opcode into register-selector codes and
// walks P1..P8, strobing the selector in P3/P5/P7; stall freezes the walk and masks strobes.
module phase_sequencer (
  input  logic clock,
  input  logic reset_n,
  phase_sequencer_if.slave bus
);

  // Phase states numbered so that the low three bits are the reported phase (P8 reads as 0).
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    P1   = 4'd1,
    P2   = 4'd2,
    P3   = 4'd3,
    P4   = 4'd4,
    P5   = 4'd5,
    P6   = 4'd6,
    P7   = 4'd7,
    P8   = 4'd8
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] sel1;
    logic [3:0] sel2;
    logic [3:0] sel3;
  } decode_t;

  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d = '0;
    case (op)
      8'h55:   d = '{legal: 1'b1, sel1: 4'd2, sel2: 4'd1, sel3: 4'd0}; // PUSH EBP
      8'h5D:   d = '{legal: 1'b1, sel1: 4'd4, sel2: 4'd2, sel3: 4'd0}; // POP EBP
      8'h89:   d = '{legal: 1'b1, sel1: 4'd0, sel2: 4'd2, sel3: 4'd0}; // MOV EBP,ESP
      8'hE8:   d = '{legal: 1'b1, sel1: 4'd3, sel2: 4'd3, sel3: 4'd2}; // CALL
      8'hC3:   d = '{legal: 1'b1, sel1: 4'd4, sel2: 4'd4, sel3: 4'd2}; // RET
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      P1:      n = P2;
      P2:      n = P3;
      P3:      n = P4;
      P4:      n = P5;
      P5:      n = P6;
      P6:      n = P7;
      P7:      n = P8;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  state_t     state;
  logic [3:0] sel1_q, sel2_q, sel3_q;
  logic       illegal_q;
  logic       take_new;
  logic       accept;
  decode_t    dec;

  // A new opcode can only land in IDLE or on the closing edge of an unstalled P8.
  assign take_new = (state == IDLE) || ((state == P8) && !bus.stall);
  assign accept   = take_new && bus.instr_valid;
  assign dec      = decode(bus.opcode);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel1_q    <= '0;
      sel2_q    <= '0;
      sel3_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !dec.legal;
      if (take_new) begin
        if (accept && dec.legal) begin
          state  <= P1;
          sel1_q <= dec.sel1;
          sel2_q <= dec.sel2;
          sel3_q <= dec.sel3;
        end else begin
          // Idle or illegal opcode: park with clean selects.
          state  <= IDLE;
          sel1_q <= '0;
          sel2_q <= '0;
          sel3_q <= '0;
        end
      end else if (!bus.stall) begin
        state <= next_phase(state);
      end
    end
  end

  // The unstalled cycle of a phase is also its last, so each strobe fires exactly once.
  assign bus.instr_ready = take_new;
  assign bus.clock_3     = (state == P3) && !bus.stall;
  assign bus.clock_5     = (state == P5) && !bus.stall;
  assign bus.clock_7     = (state == P7) && !bus.stall;
  assign bus.instr_done  = (state == P8) && !bus.stall;
  assign bus.select_1    = sel1_q;
  assign bus.select_2    = sel2_q;
  assign bus.select_3    = sel3_q;
  assign bus.phase       = state[2:0];
  assign bus.busy        = (state != IDLE);
  assign bus.illegal_op  = illegal_q;

  strobe_onehot_a: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0({bus.clock_3, bus.clock_5, bus.clock_7}));

  state_legal_a: assert property (@(posedge clock) disable iff (!reset_n)
    state inside {IDLE, P1, P2, P3, P4, P5, P6, P7, P8});

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized and directed check of phase_sequencer against a phase-counter reference model.
module tb_phase_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: instruction progress as an integer 0 (idle) .. 8 (final phase).
  int         m_stage;
  logic [3:0] m_s1, m_s2, m_s3;
  logic       m_ill;

  logic [7:0] legal_ops [5] = '{8'h55, 8'h5D, 8'h89, 8'hE8, 8'hC3};

  phase_sequencer_if bus();

  phase_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [12:0] ref_decode(input logic [7:0] op);
    case (op)
      8'h55:   return {1'b1, 4'd2, 4'd1, 4'd0};
      8'h5D:   return {1'b1, 4'd4, 4'd2, 4'd0};
      8'h89:   return {1'b1, 4'd0, 4'd2, 4'd0};
      8'hE8:   return {1'b1, 4'd3, 4'd3, 4'd2};
      8'hC3:   return {1'b1, 4'd4, 4'd4, 4'd2};
      default: return 13'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return (m_stage == 0) || ((m_stage == 8) && !bus.stall);
  endfunction

  task automatic model_reset();
    m_stage = 0;
    m_s1 = '0;
    m_s2 = '0;
    m_s3 = '0;
    m_ill = 1'b0;
  endtask

  task automatic compare_all();
    if (!reset_n) model_reset();
    check("instr_ready", {31'd0, bus.instr_ready}, {31'd0, m_ready()});
    check("clock_3",     {31'd0, bus.clock_3},     {31'd0, (m_stage == 3) && !bus.stall});
    check("clock_5",     {31'd0, bus.clock_5},     {31'd0, (m_stage == 5) && !bus.stall});
    check("clock_7",     {31'd0, bus.clock_7},     {31'd0, (m_stage == 7) && !bus.stall});
    check("instr_done",  {31'd0, bus.instr_done},  {31'd0, (m_stage == 8) && !bus.stall});
    check("busy",        {31'd0, bus.busy},        {31'd0, m_stage != 0});
    check("phase",       {29'd0, bus.phase},       (m_stage == 8) ? 32'd0 : m_stage);
    check("select_1",    {28'd0, bus.select_1},    {28'd0, m_s1});
    check("select_2",    {28'd0, bus.select_2},    {28'd0, m_s2});
    check("select_3",    {28'd0, bus.select_3},    {28'd0, m_s3});
    check("illegal_op",  {31'd0, bus.illegal_op},  {31'd0, m_ill});
  endtask

  task automatic model_update();
    logic [12:0] d;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_ill = 1'b0;
    if (m_ready()) begin
      d = ref_decode(bus.opcode);
      if (bus.instr_valid && d[12]) begin
        m_stage = 1;
        {m_s1, m_s2, m_s3} = d[11:0];
      end else begin
        m_stage = 0;
        m_s1 = '0;
        m_s2 = '0;
        m_s3 = '0;
        m_ill = bus.instr_valid;
      end
    end else if (!bus.stall) begin
      m_stage++;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic st);
    bus.instr_valid = v;
    bus.opcode = op;
    bus.stall = st;
  endtask

  task automatic sample();
    @(negedge clock);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    model_reset();

    // Reset state
    sample();
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_phase", {29'd0, bus.phase}, 32'd0);
    adv();
    reset_n = 1'b1;

    // PUSH EBP accepted on the first edge after reset release
    drive(1'b1, 8'h55, 1'b0);
    sample();
    check("push_ready", {31'd0, bus.instr_ready}, 32'd1);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      sample();
      case (k)
        1: check("push_p1", {29'd0, bus.phase}, 32'd1);
        3: begin
          check("push_c3", {31'd0, bus.clock_3}, 32'd1);
          check("push_s1", {28'd0, bus.select_1}, 32'd2);
        end
        5: begin
          check("push_c5", {31'd0, bus.clock_5}, 32'd1);
          check("push_s2", {28'd0, bus.select_2}, 32'd1);
        end
        7: begin
          check("push_c7", {31'd0, bus.clock_7}, 32'd1);
          check("push_s3", {28'd0, bus.select_3}, 32'd0);
        end
        8: begin
          check("push_done",  {31'd0, bus.instr_done}, 32'd1);
          check("push_p8",    {29'd0, bus.phase}, 32'd0);
          check("push_busy8", {31'd0, bus.busy}, 32'd1);
        end
        default: ;
      endcase
      adv();
    end
    sample();
    check("push_idle", {31'd0, bus.busy}, 32'd0);
    adv();

    // CALL then RET held valid: RET lands on the closing edge of CALL's P8
    drive(1'b1, 8'hE8, 1'b0);
    cyc();
    drive(1'b1, 8'hC3, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      sample();
      case (k)
        3: check("call_s1", {28'd0, bus.select_1}, 32'd3);
        8: begin
          check("call_ready8", {31'd0, bus.instr_ready}, 32'd1);
          check("call_done",   {31'd0, bus.instr_done}, 32'd1);
        end
        9:  check("ret_p1", {29'd0, bus.phase}, 32'd1);
        11: begin
          check("ret_c3", {31'd0, bus.clock_3}, 32'd1);
          check("ret_s1", {28'd0, bus.select_1}, 32'd4);
        end
        15: begin
          check("ret_c7", {31'd0, bus.clock_7}, 32'd1);
          check("ret_s3", {28'd0, bus.select_3}, 32'd2);
        end
        16: check("ret_done", {31'd0, bus.instr_done}, 32'd1);
        default: ;
      endcase
      adv();
      if (k == 8) drive(1'b0, 8'h00, 1'b0);
    end
    cyc();

    // MOV with stall over T+3..T+5
    drive(1'b1, 8'h89, 1'b0);
    cyc();
    for (int k = 1; k <= 11; k++) begin
      drive(1'b0, 8'h00, (k >= 3) && (k <= 5));
      sample();
      if (k >= 3 && k <= 5) check("mov_c3_stalled", {31'd0, bus.clock_3}, 32'd0);
      if (k == 6)  check("mov_c3",   {31'd0, bus.clock_3}, 32'd1);
      if (k == 8)  check("mov_c5",   {31'd0, bus.clock_5}, 32'd1);
      if (k == 11) check("mov_done", {31'd0, bus.instr_done}, 32'd1);
      adv();
    end
    cyc();

    // Illegal opcode followed immediately by POP
    drive(1'b1, 8'hFF, 1'b0);
    cyc();
    drive(1'b1, 8'h5D, 1'b0);
    sample();
    check("ill_pulse", {31'd0, bus.illegal_op},  32'd1);
    check("ill_idle",  {31'd0, bus.busy},        32'd0);
    check("ill_ready", {31'd0, bus.instr_ready}, 32'd1);
    adv();
    drive(1'b0, 8'h00, 1'b0);
    sample();
    check("pop_p1",   {29'd0, bus.phase},      32'd1);
    check("pop_s1",   {28'd0, bus.select_1},   32'd4);
    check("ill_once", {31'd0, bus.illegal_op}, 32'd0);
    adv();
    for (int k = 3; k <= 9; k++) begin
      sample();
      if (k == 9) check("pop_done", {31'd0, bus.instr_done}, 32'd1);
      adv();
    end
    cyc();

    // RET aborted by reset in its P4
    drive(1'b1, 8'hC3, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0);
    for (int k = 1; k <= 3; k++) cyc();
    reset_n = 1'b0;
    #1;
    compare_all();
    check("abort_busy",  {31'd0, bus.busy},     32'd0);
    check("abort_phase", {29'd0, bus.phase},    32'd0);
    check("abort_sel1",  {28'd0, bus.select_1}, 32'd0);
    sample();
    adv();
    reset_n = 1'b1;
    sample();
    check("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    adv();
    for (int k = 0; k < 4; k++) cyc();

    // Randomized traffic with stalls, illegal opcodes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] op;
      op = ($urandom % 4 != 0) ? legal_ops[$urandom % 5] : 8'($urandom);
      drive(($urandom % 10) < 6, op, ($urandom % 5) == 0);
      reset_n = ($urandom % 400) != 0;
      cyc();
    end
    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
